// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the round-robin 4-to-1 mux arbiter.
package mux4_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Mux select lines carry the owner index with its two bits swapped.
  function automatic logic [1:0] idx_to_select(input logic [IDX_W-1:0] index);
    return {index[0], index[1]};
  endfunction

endpackage

// File: rtl/mux4_rr_pick.sv
// Combinational rotate-priority picker: first requester after last_owner, wrapping.
module mux4_rr_pick
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  logic [IDX_W-1:0] cand;

  // Walk from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    found = 1'b0;
    index = last_owner;
    cand  = last_owner;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = last_owner + IDX_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter in front of a shared 4-to-1, 1-bit mux, with registered data.
// Optional per-requester grant counters are enabled with MUX4_ARB_STATS_EN.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] data_in,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         select,
  output logic               busy,
  output logic               data_out,
  output logic               data_valid
`ifdef MUX4_ARB_STATS_EN
  ,
  output logic [31:0]        grant_cnt
`endif
);

  arb_state_e        state_q;
  logic [IDX_W-1:0]  owner_q;
  logic [IDX_W-1:0]  last_q;
  logic [HOLD_W-1:0] hold_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [1:0]        select_q;
  logic              data_q;
  logic              valid_q;

  logic              keep_c;
  logic              start_c;
  logic [IDX_W-1:0]  pick_last_c;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_index;

  // While granted, a release rotates priority so the current owner goes last.
  assign pick_last_c = (state_q == GRANT) ? owner_q : last_q;
  assign keep_c      = (state_q == GRANT) && req[owner_q] &&
                       (hold_q < HOLD_W'(MAX_HOLD - 1));
  assign start_c     = pick_found && !keep_c;

  mux4_rr_pick u_pick (
    .req        (req),
    .last_owner (pick_last_c),
    .found      (pick_found),
    .index      (pick_index)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
      hold_q   <= '0;
      grant_q  <= '0;
      select_q <= 2'b00;
      data_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= (state_q == GRANT);
      if (state_q == GRANT) begin
        data_q <= data_in[owner_q];
      end

      if (state_q == GRANT && !keep_c) begin
        last_q <= owner_q;
      end

      if (keep_c) begin
        hold_q <= hold_q + HOLD_W'(1);
      end else if (start_c) begin
        state_q  <= GRANT;
        owner_q  <= pick_index;
        hold_q   <= '0;
        grant_q  <= NUM_REQ'(1) << pick_index;
        select_q <= idx_to_select(pick_index);
      end else begin
        state_q <= IDLE;
        grant_q <= '0;
      end
    end
  end

  assign grant      = grant_q;
  assign select     = select_q;
  assign busy       = (state_q == GRANT);
  assign data_out   = data_q;
  assign data_valid = valid_q;

`ifdef MUX4_ARB_STATS_EN
  logic [7:0] cnt_q [NUM_REQ];

  // Saturating count of grant starts, including self re-grants after timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (start_c && cnt_q[pick_index] != 8'hFF) begin
      cnt_q[pick_index] <= cnt_q[pick_index] + 8'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*8 +: 8] = cnt_q[g];
  end
`endif

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter sharing one 4-to-1, 1-bit mux between four requesters. Grants one requester at a time, drives the mux select lines in the team's select encoding, and registers the selected data bit with a valid flag. It sits directly in front of the existing 4-to-1 mux and owns all sequencing of its select inputs.

## Interface
- MAX_HOLD, 8: maximum consecutive granted cycles per owner; legal range 1..255.
- HOLD_W, 8: width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req  in  4  request per requester; bit i = requester i (0=a, 1=b, 2=c, 3=d).
- data_in  in  4  data bit per requester, same indexing.
- grant  out  4  one-hot grant, or all zero.
- select  out  2  mux select: select[0] = owner index bit 1, select[1] = owner index bit 0 (a=00, b=select[1] set, c=select[0] set, d=11).
- busy  out  1  high while any grant is held.
- data_out  out  1  registered data_in[owner].
- data_valid  out  1  data_out is valid.

## Operation
- States: IDLE (no owner), GRANT (owner held).
- Priority order starts at (last_owner+1) mod 4 and wraps. After reset, last_owner = 3, so requester 0 has highest priority.
- IDLE: if req != 0 at an edge, select the highest-priority requester, load the owner, clear hold_cnt, go to GRANT. Otherwise stay in IDLE.
- GRANT, evaluated each edge:
  - Keep: req[owner]=1 and hold_cnt < MAX_HOLD-1 → keep owner, hold_cnt++.
  - Release: req[owner]=0 or hold_cnt = MAX_HOLD-1 (timeout).
    - Set last_owner = owner.
    - Re-arbitrate in the same edge using the remaining req bits under the new priority order. The released owner is last in that order, so after a timeout it is re-granted only if it is the sole requester; hold_cnt then restarts at 0.
    - If no request remains, go to IDLE.
- Outputs:
  - grant is one-hot of owner in GRANT, else zero.
  - select is the encoded owner. It holds its last value in IDLE and is 00 after reset.
  - busy = (state == GRANT).
- Data path: each edge, data_valid <= busy and data_out <= data_in[owner] if busy. When not busy, data_out holds its value.
- Requests that assert and drop while another owner holds the grant are lost; no request is latched.

## Timing
- Reset values: grant=0000, select=00, busy=0, data_out=0, data_valid=0, state=IDLE, hold_cnt=0, last_owner=3.
- Reset asserted mid-grant: all of the above apply at the next edge, and the in-flight data_valid is dropped.
- Request-to-grant latency: 1 cycle. req sampled at edge N gives grant visible after edge N.
- Grant-to-data latency: 1 cycle. data_out and data_valid lag grant and select by exactly one edge.
- Handover between owners has no bubble: grant moves directly from one owner to the next at a single edge.
- Release has zero extra latency: req[owner] falling before edge N removes the grant after edge N.
- Maximum continuous ownership is MAX_HOLD cycles when other requesters are waiting.
- MAX_HOLD=1: every grant lasts exactly one cycle, giving strict per-cycle rotation.

## Configuration
- MUX4_ARB_STATS_EN defined:
  - Adds output grant_cnt (4 x 8 bits, flattened to 32).
  - Each requester's counter increments by 1 on every edge that starts a new grant to that requester, including a self re-grant after timeout.
  - Counters saturate at 255 and clear on reset.
- MUX4_ARB_STATS_EN undefined: the port and the counters are absent, and all other behaviour is identical.

## Structure
- Shared package mux4_arb_pkg holds:
  - state enum (IDLE, GRANT);
  - function idx_to_select(index) implementing the bit-swapped encoding;
  - constant NUM_REQ = 4.
- One sub-module, mux4_rr_pick: combinational rotate-priority picker with inputs req[3:0] and last_owner[1:0], outputs found and index[1:0]. It is instantiated once in the top.
- The top holds the state register, owner, hold_cnt, last_owner, the data register and the optional stats counters.

## Test plan
- Reset, then req=0001 → grant=0001 and select=00 after 1 edge; data_in=0001 → data_out=1, data_valid=1 one edge later.
- req=1111 held, MAX_HOLD=8 → grant sequence 0001, 0010, 0100, 1000, 0001, each held exactly 8 cycles with no zero-grant cycles between.
- Owner 2 (c) granted; drop req[2] while req=1001 → next edge grant=1000 (d, select=11), not 0001.
- Only req[1] held for 20 cycles with MAX_HOLD=8 → grant=0010 continuously, busy never drops; with MUX4_ARB_STATS_EN, grant_cnt[1]=3.
- Reset asserted while grant=0100 → next edge grant=0000, select=00, data_valid=0; after reset release with req=0110 → grant=0010.
- MAX_HOLD=1, req=0101 → grant alternates 0001, 0100 every cycle; data_out follows data_in[0] and data_in[2] with one-cycle lag.
